// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage instruction attributes in, stall/flush/forward
// controls and debug event counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_Rn;
   logic [4:0]       id_Ab;
   logic             id_use_a;
   logic             id_use_b;
   logic [4:0]       id_Rd;
   logic             id_RegWrite;
   logic             id_MemRead;
   logic             id_set_flags;
   logic             id_bcond;
   logic             br_taken;
   logic             stall;
   logic             bubble;
   logic             flush_if;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_valid, id_Rn, id_Ab, id_use_a, id_use_b, id_Rd,
             id_RegWrite, id_MemRead, id_set_flags, id_bcond, br_taken,
      input  stall, bubble, flush_if, fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_Rn, id_Ab, id_use_a, id_use_b, id_Rd,
             id_RegWrite, id_MemRead, id_set_flags, id_bcond, br_taken,
      output stall, bubble, flush_if, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// LEGv8 five-stage hazard controller: shadow EX/MEM/WB destination tracking,
// load-use and flag stalls, IF flush on taken branch, EX operand forwarding.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         reset,
   hazard_ctrl_if.slave hz
);

   localparam logic [4:0] XZR = 5'd31;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic       set_flags;
      logic [4:0] rn;
      logic [4:0] ab;
      logic       use_a;
      logic       use_b;
   } ex_entry_t;

   ex_entry_t        ex_q, ex_d;
   logic             mem_vld_q, mem_rw_q, mem_mr_q;
   logic [4:0]       mem_rd_q;
   logic             wb_vld_q, wb_rw_q;
   logic [4:0]       wb_rd_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic lu_hit, flag_hit, stall, flush;

   // MEM is the newer producer so it wins; loads in MEM are never a source.
   function automatic logic [1:0] fwd_sel(
      input logic       use_op,
      input logic [4:0] src,
      input logic       m_vld,
      input logic       m_rw,
      input logic       m_mr,
      input logic [4:0] m_rd,
      input logic       w_vld,
      input logic       w_rw,
      input logic [4:0] w_rd
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (use_op && m_vld && m_rw && !m_mr && (m_rd == src) && (m_rd != XZR))
         sel = 2'b01;
      else if (use_op && w_vld && w_rw && (w_rd == src) && (w_rd != XZR))
         sel = 2'b10;
      return sel;
   endfunction

   assign lu_hit   = hz.id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != XZR) &&
                     ((hz.id_use_a && (hz.id_Rn == ex_q.rd)) ||
                      (hz.id_use_b && (hz.id_Ab == ex_q.rd)));
   assign flag_hit = hz.id_valid && hz.id_bcond && ex_q.valid && ex_q.set_flags;
   assign stall    = lu_hit || flag_hit;
   assign flush    = hz.br_taken && !stall;

   always_comb begin
      ex_d = '0;
      if (hz.id_valid && !stall) begin
         ex_d.valid     = 1'b1;
         ex_d.rd        = hz.id_Rd;
         ex_d.regwrite  = hz.id_RegWrite;
         ex_d.memread   = hz.id_MemRead;
         ex_d.set_flags = hz.id_set_flags;
         ex_d.rn        = hz.id_Rn;
         ex_d.ab        = hz.id_Ab;
         ex_d.use_a     = hz.id_use_a;
         ex_d.use_b     = hz.id_use_b;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush && !(&flush_cnt_q))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // Shadow pipeline advance: ID -> EX -> MEM -> WB
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q        <= '0;
         mem_vld_q   <= 1'b0;
         mem_rw_q    <= 1'b0;
         mem_mr_q    <= 1'b0;
         wb_vld_q    <= 1'b0;
         wb_rw_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_vld_q   <= ex_q.valid;
         mem_rw_q    <= ex_q.regwrite;
         mem_mr_q    <= ex_q.memread;
         wb_vld_q    <= mem_vld_q;
         wb_rw_q     <= mem_rw_q;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_rd_q <= ex_q.rd;
      wb_rd_q  <= mem_rd_q;
   end

   assign hz.stall     = stall;
   assign hz.bubble    = stall;
   assign hz.flush_if  = flush;
   assign hz.fwd_a     = fwd_sel(ex_q.use_a, ex_q.rn, mem_vld_q, mem_rw_q, mem_mr_q,
                                 mem_rd_q, wb_vld_q, wb_rw_q, wb_rd_q);
   assign hz.fwd_b     = fwd_sel(ex_q.use_b, ex_q.ab, mem_vld_q, mem_rw_q, mem_mr_q,
                                 mem_rd_q, wb_vld_q, wb_rw_q, wb_rd_q);
   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a 16-bit-counter instance plus a 2-bit-counter
// instance driven with identical stimulus so counter saturation is reachable.
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(16)) hif ();
   hazard_ctrl_if #(.CNT_W(2))  hsm ();

   hazard_ctrl #(.CNT_W(16)) dut    (.clk(clk), .reset(reset), .hz(hif));
   hazard_ctrl #(.CNT_W(2))  dut_sm (.clk(clk), .reset(reset), .hz(hsm));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // v rn ab ua ub rd rw mr sf bc br
   task automatic drive(input int v, input int rn, input int ab, input int ua, input int ub,
                        input int rd, input int rw, input int mr, input int sf, input int bc,
                        input int br);
      hif.id_valid = 1'(v);      hsm.id_valid = 1'(v);
      hif.id_Rn = 5'(rn);        hsm.id_Rn = 5'(rn);
      hif.id_Ab = 5'(ab);        hsm.id_Ab = 5'(ab);
      hif.id_use_a = 1'(ua);     hsm.id_use_a = 1'(ua);
      hif.id_use_b = 1'(ub);     hsm.id_use_b = 1'(ub);
      hif.id_Rd = 5'(rd);        hsm.id_Rd = 5'(rd);
      hif.id_RegWrite = 1'(rw);  hsm.id_RegWrite = 1'(rw);
      hif.id_MemRead = 1'(mr);   hsm.id_MemRead = 1'(mr);
      hif.id_set_flags = 1'(sf); hsm.id_set_flags = 1'(sf);
      hif.id_bcond = 1'(bc);     hsm.id_bcond = 1'(bc);
      hif.br_taken = 1'(br);     hsm.br_taken = 1'(br);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      tests++;
      assert (obs === 32'(exp)) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input int st, input int fl);
      chk({tag, ".stall"},     32'(hif.stall),    st);
      chk({tag, ".bubble"},    32'(hif.bubble),   st);
      chk({tag, ".flush_if"},  32'(hif.flush_if), fl);
      chk({tag, ".sm_stall"},  32'(hsm.stall),    st);
      chk({tag, ".sm_bubble"}, 32'(hsm.bubble),   st);
      chk({tag, ".sm_flush"},  32'(hsm.flush_if), fl);
   endtask

   task automatic chk_fwd(input string tag, input int a, input int b);
      chk({tag, ".fwd_a"},    32'(hif.fwd_a), a);
      chk({tag, ".fwd_b"},    32'(hif.fwd_b), b);
      chk({tag, ".sm_fwd_a"}, 32'(hsm.fwd_a), a);
      chk({tag, ".sm_fwd_b"}, 32'(hsm.fwd_b), b);
   endtask

   task automatic chk_cnt(input string tag, input int s, input int f);
      chk({tag, ".stall_cnt"},    32'(hif.stall_cnt), s);
      chk({tag, ".flush_cnt"},    32'(hif.flush_cnt), f);
      chk({tag, ".sm_stall_cnt"}, 32'(hsm.stall_cnt), (s > 3) ? 3 : s);
      chk({tag, ".sm_flush_cnt"}, 32'(hsm.flush_cnt), (f > 3) ? 3 : f);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      tick();
      tick();
      chk_ctl("rst", 0, 0);
      chk_fwd("rst", 0, 0);
      chk_cnt("rst", 0, 0);
      reset = 1'b0;

      // LDUR X1,[X2] ; ADD X2,X1,X3
      drive(1, 2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
      chk_ctl("ld_issue", 0, 0);
      tick(); drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0);
      chk_ctl("lu_stall", 1, 0);
      tick();
      chk_ctl("lu_release", 0, 0);
      chk_cnt("lu", 1, 0);
      tick(); idle();
      chk_fwd("lu_wb", 2, 0);

      // ADD X1,X4,X5 ; SUB X6,X7,X1
      tick(); drive(1, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0);
      tick(); drive(1, 7, 1, 1, 1, 6, 1, 0, 0, 0, 0);
      chk_ctl("alu_nostall", 0, 0);
      tick(); idle();
      chk_fwd("mem_fwd", 0, 1);
      // same pair with ADD X9,X10,X11 between
      tick(); drive(1, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0);
      tick(); drive(1, 10, 11, 1, 1, 9, 1, 0, 0, 0, 0);
      tick(); drive(1, 7, 1, 1, 1, 6, 1, 0, 0, 0, 0);
      tick(); idle();
      chk_fwd("wb_fwd", 0, 2);

      // LDUR X31 ; ADD X2,X31,X3 ; then ALU writes to X31 seen from MEM and WB
      tick(); drive(1, 2, 0, 1, 0, 31, 1, 1, 0, 0, 0);
      tick(); drive(1, 31, 3, 1, 1, 2, 1, 0, 0, 0, 0);
      chk_ctl("xzr_ld", 0, 0);
      tick(); drive(1, 4, 5, 1, 1, 31, 1, 0, 0, 0, 0);
      chk_fwd("xzr_ld", 0, 0);
      tick(); drive(1, 31, 3, 1, 1, 2, 1, 0, 0, 0, 0);
      tick(); drive(1, 31, 3, 1, 1, 2, 1, 0, 0, 0, 0);
      chk_fwd("xzr_mem", 0, 0);
      tick(); drive(1, 4, 5, 1, 1, 1, 1, 0, 0, 0, 0);
      chk_fwd("xzr_wb", 0, 0);
      // X1 in both MEM and WB
      tick(); drive(1, 6, 7, 1, 1, 1, 1, 0, 0, 0, 0);
      tick(); drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0);
      tick(); idle();
      chk_fwd("mem_wins", 1, 0);

      // SUBS X1,X2,X3 ; B.LT taken
      tick(); drive(1, 2, 3, 1, 1, 1, 1, 0, 1, 0, 0);
      chk_ctl("subs", 0, 0);
      tick(); drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk_ctl("flag_stall", 1, 0);
      tick();
      chk_ctl("flag_flush", 0, 1);
      chk_cnt("flag", 2, 0);
      tick(); idle();
      chk_ctl("post_flush", 0, 0);
      chk_cnt("post_flush", 2, 1);

      // flag-setting load followed by a B.cond reading its destination
      tick(); drive(1, 2, 0, 1, 0, 1, 1, 1, 1, 0, 0);
      tick(); drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      chk_ctl("both_stall", 1, 0);
      tick();
      chk_ctl("both_release", 0, 0);
      chk_cnt("both", 3, 1);

      // invalid ID slot reading the load target and claiming to write X5
      tick(); drive(1, 2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
      tick(); drive(0, 1, 0, 1, 0, 5, 1, 0, 0, 0, 0);
      chk_ctl("inv_nostall", 0, 0);
      tick(); drive(1, 5, 3, 1, 1, 2, 1, 0, 0, 0, 0);
      tick(); idle();
      chk_fwd("inv_noadv", 0, 0);
      chk_cnt("inv", 3, 1);

      for (int i = 0; i < 3; i++) begin
         tick(); drive(1, 2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
         tick(); drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0);
         chk_ctl("sat_stall", 1, 0);
         tick();
      end
      chk_cnt("sat_stall", 6, 1);

      tick(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk_ctl("br_idle", 0, 1);
      repeat (4) tick();
      idle();
      chk_cnt("sat_flush", 6, 5);

      // reset asserted while a load-use stall is active
      tick(); drive(1, 2, 0, 1, 0, 1, 1, 1, 0, 0, 0);
      tick(); drive(1, 1, 3, 1, 1, 2, 1, 0, 0, 0, 0);
      chk_ctl("pre_rst", 1, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk_ctl("rst_mid", 0, 0);
      chk_fwd("rst_mid", 0, 0);
      chk_cnt("rst_mid", 0, 0);
      tick(); idle();
      chk_fwd("rst_no_stale", 0, 0);
      chk_cnt("rst_after", 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage LEGv8 CPU. It sits beside the ID stage and regfile. It tracks the destination registers of in-flight instructions in a shadow pipeline (EX, MEM, WB) and produces four kinds of control:
- load-use and flag stalls that hold PC and IF/ID;
- bubble insertion into ID/EX;
- IF flush on a taken branch;
- forwarding selects for the EX-stage ALU operands.

Saturating event counters expose stall and flush activity for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_Rn  in  5  first read register of the ID instruction.
- id_Ab  in  5  second read register (post-Reg2Loc mux).
- id_use_a, id_use_b  in  1 each  the ID instruction reads Rn / Ab.
- id_Rd  in  5  destination of the ID instruction.
- id_RegWrite  in  1  the ID instruction writes Rd.
- id_MemRead  in  1  the ID instruction is LDUR.
- id_set_flags  in  1  the ID instruction updates flags (ADDS/SUBS).
- id_bcond  in  1  the ID instruction is B.cond (reads flags).
- br_taken  in  1  ID branch resolved taken.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  load a NOP into ID/EX this cycle.
- flush_if  out  1  squash the instruction in IF (IF/ID gets a NOP).
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 from MEM-stage result, 10 from WB-stage data.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

## Operation
- Shadow entries EX, MEM and WB each hold {valid, rd, regwrite, memread, set_flags}. The EX entry also holds {rn, ab, use_a, use_b}.
- Register 31 (XZR) is never a hazard source. Any match with rd==31 is ignored for stall and for forwarding.
- Load-use stall: assert when all of the following hold.
  - id_valid.
  - EX.valid, EX.memread, EX.rd!=31.
  - (id_use_a && id_Rn==EX.rd) || (id_use_b && id_Ab==EX.rd).
- Flag stall: assert when id_valid && id_bcond && EX.valid && EX.set_flags.
- stall = load-use stall OR flag stall. bubble = stall.
- flush_if = br_taken && !stall. br_taken is ignored while stall is asserted, because the branch has not resolved yet.
- Shadow advance on each posedge: WB<=MEM, MEM<=EX.
  - EX <= ID fields when id_valid && !stall.
  - EX <= invalid otherwise (bubble).
- Forwarding for operand a, evaluated against the EX entry; fwd_b uses the same rules with ab/use_b.
  - 01 if EX.use_a && MEM.valid && MEM.regwrite && !MEM.memread && MEM.rd==EX.rn && rd!=31.
  - else 10 if EX.use_a && WB.valid && WB.regwrite && WB.rd==EX.rn && rd!=31.
  - else 00.
- MEM has priority over WB, because it is the newer value.
- A load in MEM is never forwarded. The load-use stall already guarantees the load reaches WB before the consumer reaches EX.
- stall_cnt increments on each cycle stall=1. flush_cnt increments on each cycle flush_if=1. Both saturate at all-ones and never wrap.

## Timing
- stall, bubble and flush_if are combinational from the shadow state and the ID inputs in the same cycle.
- fwd_a and fwd_b are combinational from registered state only. They are valid for the entire cycle the consumer occupies EX.
- Load-use: exactly 1 stall cycle. On the next cycle the load is in MEM, EX holds the bubble, and no stall is asserted.
- Flag stall: exactly 1 cycle. Flags are written at the end of EX.
- Simultaneous load-use and flag stall: one stall cycle. Only one increment to stall_cnt.
- Reset, including mid-stall:
  - all shadow entries invalid;
  - stall=0, bubble=0, flush_if=0 (given br_taken=0);
  - fwd_a=fwd_b=00;
  - counters 0.
- No stale forwarding is permitted after reset.
- id_valid=0 never causes a stall and never advances a valid entry into EX.

## Test plan
- LDUR X1 then ADD X2,X1,X3 back-to-back:
  - stall=bubble=1 for exactly 1 cycle, stall_cnt=1;
  - when the ADD is in EX, fwd_a=10.
- ADD X1,X4,X5 then SUB X6,X7,X1: no stall; fwd_b=01 in the SUB's EX cycle. Inserting one unrelated instruction between them gives fwd_b=10.
- LDUR X31 then ADD X2,X31,X3: no stall, fwd_a=00. Also ADD writing X1 in both MEM and WB: fwd_a=01 (MEM wins).
- SUBS X1,X2,X3 then B.LT with br_taken=1:
  - 1 stall cycle with flush_if=0;
  - next cycle flush_if=1;
  - flush_cnt=1, stall_cnt=1.
- Preload stall_cnt to 0xFFFE via repeated load-use pairs (or a forced bench value), then 3 more stalls: stall_cnt reads 0xFFFF and holds.
- Assert reset during a load-use stall: next cycle stall=0, fwd_a=fwd_b=00, counters 0. A following ADD using X1 shows no forwarding.
